// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if
// Bundles the two requester handshakes, their data returns and the ROM
// read port shared by rom_port_arbiter.
//   REQx/ADDRx   : requester x read request and address (held until GNTx)
//   GNTx         : combinational accept, transfer when REQx && GNTx at CLK edge
//   DVALIDx/DATAx: registered one-cycle return strobe and held read data
//   ROM_ADDR     : registered address into the synchronous ROM
//   ROM_DATA     : ROM read data (registered inside the ROM)
// Modports: slave = arbiter side, master = requester/ROM side.
interface rom_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  REQ0;
    logic [ADDR_WIDTH-1:0] ADDR0;
    logic                  GNT0;
    logic                  DVALID0;
    logic [DATA_WIDTH-1:0] DATA0;
    logic                  REQ1;
    logic [ADDR_WIDTH-1:0] ADDR1;
    logic                  GNT1;
    logic                  DVALID1;
    logic [DATA_WIDTH-1:0] DATA1;
    logic [ADDR_WIDTH-1:0] ROM_ADDR;
    logic [DATA_WIDTH-1:0] ROM_DATA;

    modport slave (
        input  REQ0, ADDR0, REQ1, ADDR1, ROM_DATA,
        output GNT0, DVALID0, DATA0, GNT1, DVALID1, DATA1, ROM_ADDR
    );

    modport master (
        output REQ0, ADDR0, REQ1, ADDR1, ROM_DATA,
        input  GNT0, DVALID0, DATA0, GNT1, DVALID1, DATA1, ROM_ADDR
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
// Shares the single synchronous program-ROM read port between requester 0
// (instruction fetch) and requester 1 (secondary reader). One access is
// issued per clock; each return comes back three cycles after the transfer
// as a one-cycle DVALIDx strobe with DATAx held until the next return.
// Ports:
//   CLK    : system clock, rising edge
//   RESETN : synchronous active-low reset
//   bus    : rom_port_arbiter_if.slave (request/grant, returns, ROM port)
// Optional build macro ROM_ARB_FIXED_PRIO_EN: requester 0 gets strict
// priority instead of round-robin; pipeline and latency are unchanged.
module rom_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                CLK,
    input  logic                RESETN,
    rom_port_arbiter_if.slave   bus
);

    typedef enum logic {
        REQ_SEL0 = 1'b0,
        REQ_SEL1 = 1'b1
    } req_sel_e;

    logic                  gnt0;
    logic                  gnt1;

    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                  s1_vld_q, s1_vld_d;
    req_sel_e              s1_tag_q, s1_tag_d;
    logic                  s2_vld_q, s2_vld_d;
    req_sel_e              s2_tag_q, s2_tag_d;
    logic                  dvalid0_q, dvalid0_d;
    logic                  dvalid1_q, dvalid1_d;
    logic [DATA_WIDTH-1:0] data0_q, data0_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
`ifndef ROM_ARB_FIXED_PRIO_EN
    req_sel_e              last_winner_q, last_winner_d;
`endif

    // Grant: never while in reset, at most one per cycle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (RESETN) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
            if (bus.REQ0) begin
                gnt0 = 1'b1;
            end else if (bus.REQ1) begin
                gnt1 = 1'b1;
            end
`else
            if (bus.REQ0 && bus.REQ1) begin
                // Tie goes to whoever did not win the last transfer.
                gnt0 = (last_winner_q == REQ_SEL1);
                gnt1 = (last_winner_q == REQ_SEL0);
            end else begin
                gnt0 = bus.REQ0;
                gnt1 = bus.REQ1;
            end
`endif
        end
    end

    always_comb begin
        rom_addr_d = rom_addr_q;
        if (gnt0) begin
            rom_addr_d = bus.ADDR0;
        end else if (gnt1) begin
            rom_addr_d = bus.ADDR1;
        end

        s1_vld_d = gnt0 | gnt1;
        s1_tag_d = gnt1 ? REQ_SEL1 : REQ_SEL0;

        // ROM samples rom_addr_q on the same edge that moves stage 1 to 2.
        s2_vld_d = s1_vld_q;
        s2_tag_d = s1_tag_q;

        dvalid0_d = s2_vld_q && (s2_tag_q == REQ_SEL0);
        dvalid1_d = s2_vld_q && (s2_tag_q == REQ_SEL1);
        data0_d   = dvalid0_d ? bus.ROM_DATA : data0_q;
        data1_d   = dvalid1_d ? bus.ROM_DATA : data1_q;

`ifndef ROM_ARB_FIXED_PRIO_EN
        last_winner_d = last_winner_q;
        if (gnt0) begin
            last_winner_d = REQ_SEL0;
        end else if (gnt1) begin
            last_winner_d = REQ_SEL1;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            rom_addr_q    <= '0;
            s1_vld_q      <= 1'b0;
            s1_tag_q      <= REQ_SEL0;
            s2_vld_q      <= 1'b0;
            s2_tag_q      <= REQ_SEL0;
            dvalid0_q     <= 1'b0;
            dvalid1_q     <= 1'b0;
            data0_q       <= '0;
            data1_q       <= '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
            last_winner_q <= REQ_SEL1;
`endif
        end else begin
            rom_addr_q    <= rom_addr_d;
            s1_vld_q      <= s1_vld_d;
            s1_tag_q      <= s1_tag_d;
            s2_vld_q      <= s2_vld_d;
            s2_tag_q      <= s2_tag_d;
            dvalid0_q     <= dvalid0_d;
            dvalid1_q     <= dvalid1_d;
            data0_q       <= data0_d;
            data1_q       <= data1_d;
`ifndef ROM_ARB_FIXED_PRIO_EN
            last_winner_q <= last_winner_d;
`endif
        end
    end

    assign bus.GNT0     = gnt0;
    assign bus.GNT1     = gnt1;
    assign bus.ROM_ADDR = rom_addr_q;
    assign bus.DVALID0  = dvalid0_q;
    assign bus.DVALID1  = dvalid1_q;
    assign bus.DATA0    = data0_q;
    assign bus.DATA1    = data1_q;

endmodule
